timer_irq_src: RTL and testbench

- Programmable 16-bit down-counting timer with 8-bit prescaler; produces the active-low `timer0_int_n` request consumed by the interrupt controller at level 6 (vector 0x40).
- Registers sit on the CPU 16-bit bus through the address decoder's select strobes.
- Interrupt source state lives here: the pending flag is held until software clears it (write-1-to-clear).
- The interrupt controller stays purely combinational and edge-agnostic for this source.

---
 rtl/timer_irq_src.sv | 65 ++++++
 tb/tb_timer_irq_src.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_src.sv
// timer_irq_src: prescaled 16-bit down-counting timer with W1C pending flag and registered active-low interrupt
module timer_irq_src #(
    parameter int CNT_W = 16,
    parameter int PRE_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        wr,
    input  logic [1:0]  addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        timer0_int_n
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;
    logic ie, oneshot, pend;
    logic [PRE_W-1:0] prescale, pcnt;
    logic [CNT_W-1:0] reload, cnt;
    logic wr_ctrl, wr_reload, wr_count, wr_status, start, tick, expire;
    always_comb begin
        wr_ctrl   = sel && wr && addr == 2'd0;
        wr_reload = sel && wr && addr == 2'd1;
        wr_count  = sel && wr && addr == 2'd2;
        wr_status = sel && wr && addr == 2'd3;
        start     = state == IDLE && wr_ctrl && data_in[0];
        tick      = state == RUN && pcnt == '0;
        expire    = tick && cnt == '0;
        state_nxt = state == IDLE ? (start ? RUN : IDLE)
                  : (((wr_ctrl && !data_in[0]) || (expire && oneshot)) ? IDLE : RUN);
        data_out  = addr == 2'd0 ? 16'({prescale, 5'd0, oneshot, ie, state == RUN})
                  : addr == 2'd1 ? 16'(reload)
                  : addr == 2'd2 ? 16'(cnt)
                  : {14'd0, state == RUN, pend};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ie           <= 1'b0;
            oneshot      <= 1'b0;
            prescale     <= '0;
            reload       <= '0;
            cnt          <= '0;
            pcnt         <= '0;
            pend         <= 1'b0;
            timer0_int_n <= 1'b1;
        end else begin
            state        <= state_nxt;
            timer0_int_n <= !(pend && ie);
            if (wr_ctrl) begin
                ie       <= data_in[1];
                oneshot  <= data_in[2];
                prescale <= data_in[8 +: PRE_W];
            end
            if (wr_reload) reload <= data_in[CNT_W-1:0];
            if (start) pcnt <= data_in[8 +: PRE_W];
            else if (state == RUN) pcnt <= tick ? prescale : pcnt - PRE_W'(1);
            if (wr_count) cnt <= data_in[CNT_W-1:0];
            else if (start) cnt <= reload;
            else if (tick) cnt <= expire ? reload : cnt - CNT_W'(1);
            if (expire) pend <= 1'b1;
            else if (wr_status && data_in[0]) pend <= 1'b0;
        end
    end
endmodule

// File: tb/tb_timer_irq_src.sv
// tb_timer_irq_src: randomized scenario bench; expiry timing predicted from (RELOAD+1)*(PRESCALE+1)
module tb_timer_irq_src;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [15:0] data_in = 16'd0;
    logic [15:0] data_out;
    logic        timer0_int_n;
    int cyc = 0;
    int total = 0;
    int passed = 0;

    timer_irq_src dut (
        .clk(clk), .rst(rst), .sel(sel), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(data_out), .timer0_int_n(timer0_int_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic int period(input int r, input int p);
        return (r + 1) * (p + 1);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wreg(input logic [1:0] a, input logic [15:0] d);
        sel = 1'b1; wr = 1'b1; addr = a; data_in = d;
        @(posedge clk);
        #1;
        sel = 1'b0; wr = 1'b0; data_in = 16'd0;
    endtask

    task automatic rreg(input logic [1:0] a, output logic [15:0] d);
        addr = a;
        #1;
        d = data_out;
    endtask

    task automatic wait_low(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            @(posedge clk);
            #1;
            if (timer0_int_n === 1'b0) at = cyc;
        end
    endtask

    task automatic quiesce();
        wreg(2'd0, 16'h0000);
        wreg(2'd3, 16'h0001);
        step(2);
    endtask

    task automatic test_reset();
        logic [15:0] v;
        rst = 1'b1;
        step(2);
        total++; if (timer0_int_n !== 1'b1) $display("FAIL reset_int_n: got %b exp 1", timer0_int_n); else passed++;
        for (int a = 0; a < 4; a++) begin
            rreg(2'(a), v);
            total++; if (v !== 16'h0000) $display("FAIL reset_reg%0d: got %h exp 0000", a, v); else passed++;
        end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_periodic();
        logic [15:0] v;
        int w, at, r, p;
        wreg(2'd1, 16'd3);
        rreg(2'd1, v);
        total++; if (v !== 16'h0003) $display("FAIL per_reload_rd: got %h exp 0003", v); else passed++;
        wreg(2'd0, 16'h0203);
        w = cyc;
        rreg(2'd0, v);
        total++; if (v !== 16'h0203) $display("FAIL per_ctrl_rd: got %h exp 0203", v); else passed++;
        wait_low(60, at);
        total++; if (at - w !== period(3, 2) + 1) $display("FAIL per_first_fall: got %0d exp %0d", at - w, period(3, 2) + 1); else passed++;
        rreg(2'd3, v);
        total++; if (v !== 16'h0003) $display("FAIL per_status: got %h exp 0003", v); else passed++;
        wreg(2'd3, 16'h0001);
        total++; if (timer0_int_n !== 1'b0) $display("FAIL per_clear_delay: got %b exp 0", timer0_int_n); else passed++;
        step(1);
        total++; if (timer0_int_n !== 1'b1) $display("FAIL per_clear_rise: got %b exp 1", timer0_int_n); else passed++;
        wait_low(60, at);
        total++; if (at - w !== 2 * period(3, 2) + 1) $display("FAIL per_second_fall: got %0d exp %0d", at - w, 2 * period(3, 2) + 1); else passed++;
        quiesce();
        for (int i = 0; i < 4; i++) begin
            r = int'($urandom_range(0, 6));
            p = int'($urandom_range(0, 3));
            wreg(2'd1, 16'(r));
            wreg(2'd0, {8'(p), 8'h03});
            w = cyc;
            wait_low(300, at);
            total++; if (at - w !== period(r, p) + 1) $display("FAIL per_rand_fall r=%0d p=%0d: got %0d exp %0d", r, p, at - w, period(r, p) + 1); else passed++;
            quiesce();
            rreg(2'd3, v);
            total++; if (v !== 16'h0000) $display("FAIL per_rand_idle_status: got %h exp 0000", v); else passed++;
            total++; if (timer0_int_n !== 1'b1) $display("FAIL per_rand_idle_int: got %b exp 1", timer0_int_n); else passed++;
        end
    endtask

    task automatic test_oneshot();
        logic [15:0] v;
        wreg(2'd1, 16'd0);
        wreg(2'd0, 16'h0007);
        step(1);
        rreg(2'd3, v);
        total++; if (v !== 16'h0001) $display("FAIL os_status: got %h exp 0001", v); else passed++;
        rreg(2'd0, v);
        total++; if (v !== 16'h0006) $display("FAIL os_ctrl: got %h exp 0006", v); else passed++;
        rreg(2'd2, v);
        total++; if (v !== 16'h0000) $display("FAIL os_count: got %h exp 0000", v); else passed++;
        step(1);
        total++; if (timer0_int_n !== 1'b0) $display("FAIL os_int_low: got %b exp 0", timer0_int_n); else passed++;
        wreg(2'd2, 16'h0009);
        step(6);
        rreg(2'd2, v);
        total++; if (v !== 16'h0009) $display("FAIL os_count_stopped: got %h exp 0009", v); else passed++;
        rreg(2'd3, v);
        total++; if (v !== 16'h0001) $display("FAIL os_pend_held: got %h exp 0001", v); else passed++;
        quiesce();
    endtask

    task automatic test_simul();
        logic [15:0] v;
        int w, r, p, t;
        for (int i = 0; i < 3; i++) begin
            r = int'($urandom_range(0, 3));
            p = int'($urandom_range(0, 2));
            t = period(r, p);
            wreg(2'd1, 16'(r));
            wreg(2'd0, {8'(p), 8'h03});
            w = cyc;
            step(2 * t - 1);
            wreg(2'd3, 16'h0001);
            rreg(2'd3, v);
            total++; if (v !== 16'h0003) $display("FAIL simul_pend r=%0d p=%0d: got %h exp 0003", r, p, v); else passed++;
            total++; if (timer0_int_n !== 1'b0) $display("FAIL simul_int_now: got %b exp 0", timer0_int_n); else passed++;
            step(1);
            total++; if (timer0_int_n !== 1'b0) $display("FAIL simul_int_next: got %b exp 0", timer0_int_n); else passed++;
            quiesce();
        end
    endtask

    task automatic test_ie_gating();
        logic [15:0] v;
        logic hi;
        int r, p, t;
        r = int'($urandom_range(0, 3));
        p = int'($urandom_range(0, 2));
        t = period(r, p);
        wreg(2'd1, 16'(r));
        wreg(2'd0, {8'(p), 8'h01});
        hi = 1'b1;
        repeat (3 * t + 2) begin
            step(1);
            if (timer0_int_n !== 1'b1) hi = 1'b0;
        end
        total++; if (hi !== 1'b1) $display("FAIL ie_gated_high: got %b exp 1", hi); else passed++;
        rreg(2'd3, v);
        total++; if (v !== 16'h0003) $display("FAIL ie_status: got %h exp 0003", v); else passed++;
        wreg(2'd0, {8'(p), 8'h03});
        total++; if (timer0_int_n !== 1'b1) $display("FAIL ie_on_delay: got %b exp 1", timer0_int_n); else passed++;
        step(1);
        total++; if (timer0_int_n !== 1'b0) $display("FAIL ie_on_low: got %b exp 0", timer0_int_n); else passed++;
        wreg(2'd0, {8'(p), 8'h01});
        step(1);
        total++; if (timer0_int_n !== 1'b1) $display("FAIL ie_off_high: got %b exp 1", timer0_int_n); else passed++;
        quiesce();
    endtask

    task automatic test_count_override();
        logic [15:0] v, v0, v2;
        int k;
        wreg(2'd1, 16'h00ff);
        wreg(2'd0, 16'h0001);
        step(3);
        v0 = 16'($urandom_range(20, 200));
        wreg(2'd2, v0);
        rreg(2'd2, v);
        total++; if (v !== v0) $display("FAIL cnt_override: got %h exp %h", v, v0); else passed++;
        k = int'($urandom_range(1, 15));
        step(k);
        rreg(2'd2, v);
        total++; if (v !== v0 - 16'(k)) $display("FAIL cnt_decrement: got %h exp %h", v, v0 - 16'(k)); else passed++;
        wreg(2'd0, 16'h0000);
        rreg(2'd3, v);
        total++; if (v !== 16'h0000) $display("FAIL cnt_disable_status: got %h exp 0000", v); else passed++;
        v2 = 16'($urandom_range(1, 16'hffff));
        wreg(2'd2, v2);
        step(5);
        rreg(2'd2, v);
        total++; if (v !== v2) $display("FAIL cnt_frozen: got %h exp %h", v, v2); else passed++;
        quiesce();
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        int at;
        wreg(2'd1, 16'd3);
        wreg(2'd0, 16'h0003);
        wait_low(40, at);
        total++; if (at < 0) $display("FAIL rm_pre_fall: got %0d exp >=0", at); else passed++;
        step(2);
        rst = 1'b1;
        step(1);
        total++; if (timer0_int_n !== 1'b1) $display("FAIL rm_int_n: got %b exp 1", timer0_int_n); else passed++;
        for (int a = 0; a < 4; a++) begin
            rreg(2'(a), v);
            total++; if (v !== 16'h0000) $display("FAIL rm_reg%0d: got %h exp 0000", a, v); else passed++;
        end
        rst = 1'b0;
        step(20);
        total++; if (timer0_int_n !== 1'b1) $display("FAIL rm_after_int: got %b exp 1", timer0_int_n); else passed++;
        rreg(2'd3, v);
        total++; if (v !== 16'h0000) $display("FAIL rm_after_status: got %h exp 0000", v); else passed++;
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_simul();
        test_ie_gating();
        test_count_override();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
